// File: rtl/rgb565_axil_slave.sv
// AXI4-Lite responder for the RGB565 pixel converter: CTRL/PIX0/PIX1/SCRATCH RW, RESULT/COUNT RO.
// Optional build macro RGB565_ROUND_EN selects round-to-nearest with saturation instead of truncation.
module rgb565_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_VALID} rstate_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   wstate_t     wstate_q;
   rstate_t     rstate_q;
   logic        aw_got_q, w_got_q, bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [2:0]  awidx_q;
   logic [31:0] wdata_q, rdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] ctrl_q, pix0_q, pix1_q, scratch_q, count_q, result_q;

   logic        aw_hs, w_hs, ar_hs, wr_commit;
   logic [2:0]  wr_idx_d;
   logic [31:0] wr_data_d, rd_data_d;
   logic [3:0]  wr_strb_d;
   logic        unused_ok;

   function automatic logic [15:0] to_rgb565(input logic [23:0] rgb);
`ifdef RGB565_ROUND_EN
      logic [8:0] r, g, b;
      logic [4:0] r5, b5;
      logic [5:0] g6;
      r  = {1'b0, rgb[23:16]} + 9'd4;
      g  = {1'b0, rgb[15:8]}  + 9'd2;
      b  = {1'b0, rgb[7:0]}   + 9'd4;
      r5 = r[8] ? 5'd31 : r[7:3];
      g6 = g[8] ? 6'd63 : g[7:2];
      b5 = b[8] ? 5'd31 : b[7:3];
      return {r5, g6, b5};
`else
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
`endif
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
      logic [31:0] m;
      m = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) m[8*i +: 8] = d[8*i +: 8];
      return m;
   endfunction

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Readiness follows the capture flags directly so it is already up in the first cycle out of reset.
   assign S_AXI_AWREADY = ~ARESET & ~aw_got_q & (wstate_q != W_RESP);
   assign S_AXI_WREADY  = ~ARESET & ~w_got_q  & (wstate_q != W_RESP);
   assign S_AXI_ARREADY = ~ARESET & (rstate_q == R_IDLE);
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

   assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs      = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
   assign wr_commit = (aw_got_q | aw_hs) & (w_got_q | w_hs);

   always_comb begin
      wr_idx_d  = aw_hs ? S_AXI_AWADDR[4:2] : awidx_q;
      wr_data_d = w_hs  ? S_AXI_WDATA       : wdata_q;
      wr_strb_d = w_hs  ? S_AXI_WSTRB       : wstrb_q;
      case (S_AXI_ARADDR[4:2])
         3'd0:    rd_data_d = ctrl_q;
         3'd1:    rd_data_d = pix0_q;
         3'd2:    rd_data_d = pix1_q;
         3'd3:    rd_data_d = scratch_q;
         3'd4:    rd_data_d = result_q;
         3'd5:    rd_data_d = count_q;
         default: rd_data_d = 32'd0;
      endcase
   end

   // Write channel: capture AW and W independently, commit when both are held.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate_q <= W_IDLE;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         case (wstate_q)
            W_IDLE, W_WAIT: begin
               if (aw_hs) awidx_q <= S_AXI_AWADDR[4:2];
               if (w_hs) begin
                  wdata_q <= S_AXI_WDATA;
                  wstrb_q <= S_AXI_WSTRB;
               end
               if (wr_commit) begin
                  wstate_q <= W_RESP;
                  aw_got_q <= 1'b0;
                  w_got_q  <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= (wr_idx_d >= 3'd6) ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  aw_got_q <= aw_got_q | aw_hs;
                  w_got_q  <= w_got_q | w_hs;
                  wstate_q <= (aw_got_q | aw_hs | w_got_q | w_hs) ? W_WAIT : W_IDLE;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Register file, pixel counter and one-stage conversion pipeline.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ctrl_q    <= 32'd0;
         pix0_q    <= 32'd0;
         pix1_q    <= 32'd0;
         scratch_q <= 32'd0;
         count_q   <= 32'd0;
         result_q  <= 32'd0;
      end else begin
         result_q <= {to_rgb565(pix1_q[23:0]), to_rgb565(pix0_q[23:0])};
         if (wr_commit) begin
            case (wr_idx_d)
               3'd0: begin
                  ctrl_q <= merge_bytes(ctrl_q, wr_data_d, wr_strb_d);
                  if (wr_strb_d[0] && wr_data_d[0]) count_q <= 32'd0;
               end
               3'd1: begin
                  pix0_q <= merge_bytes(pix0_q, wr_data_d, wr_strb_d);
                  if (|wr_strb_d) count_q <= count_q + 32'd1;
               end
               3'd2: begin
                  pix1_q <= merge_bytes(pix1_q, wr_data_d, wr_strb_d);
                  if (|wr_strb_d) count_q <= count_q + 32'd1;
               end
               3'd3: scratch_q <= merge_bytes(scratch_q, wr_data_d, wr_strb_d);
               default: ;
            endcase
         end
      end
   end

   // Read channel: data sampled from pre-edge register contents at the AR handshake.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate_q <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= 32'd0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate_q <= R_VALID;
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_data_d;
                  rresp_q  <= (S_AXI_ARADDR[4:2] >= 3'd6) ? RESP_SLVERR : RESP_OKAY;
               end
            end
            R_VALID: begin
               if (S_AXI_RREADY) begin
                  rstate_q <= R_IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rgb565_axil_slave.sv
// Self-checking bench for rgb565_axil_slave: directed steps plus randomized traffic against a register-map model.
module tb_rgb565_axil_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_reg [4];
   logic [31:0] m_count;

   logic [31:0] d, exp_d, old_d;
   logic [1:0]  resp, exp_r;
   int          lat;

   rgb565_axil_slave dut (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: pixel conversion from the 8-bit channel values with plain arithmetic.
   function automatic logic [15:0] m_565(input logic [31:0] p);
      int r, g, b;
      r = (p >> 16) % 256;
      g = (p >> 8) % 256;
      b = p % 256;
`ifdef RGB565_ROUND_EN
      r = (r + 4) / 8; if (r > 31) r = 31;
      g = (g + 2) / 4; if (g > 63) g = 63;
      b = (b + 4) / 8; if (b > 31) b = 31;
`else
      r = r / 8; g = g / 4; b = b / 8;
`endif
      return 16'(r * 2048 + g * 32 + b);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
      m_count = 32'd0;
   endtask

   task automatic m_write(input logic [4:0] a, input logic [31:0] dat, input logic [3:0] s,
                          output logic [1:0] r);
      int idx;
      idx = int'(a) / 4;
      r = (idx >= 6) ? 2'b10 : 2'b00;
      if (idx < 4)
         for (int i = 0; i < 4; i++)
            if (s[i]) m_reg[idx][8*i +: 8] = dat[8*i +: 8];
      if (idx == 0 && s[0] && dat[0]) m_count = 32'd0;
      if ((idx == 1 || idx == 2) && s != 4'd0) m_count = m_count + 32'd1;
   endtask

   task automatic m_read(input logic [4:0] a, output logic [31:0] dat, output logic [1:0] r);
      int idx;
      idx = int'(a) / 4;
      r = (idx >= 6) ? 2'b10 : 2'b00;
      if (idx < 4)       dat = m_reg[idx];
      else if (idx == 4) dat = {m_565(m_reg[2]), m_565(m_reg[1])};
      else if (idx == 5) dat = m_count;
      else               dat = 32'd0;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] dat, input logic [3:0] s,
                            output logic [1:0] r, output int l);
      bit awd, wd;
      int n;
      awaddr = a; awvalid = 1'b1; wdata = dat; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      awd = 0; wd = 0; n = 0;
      while (!(awd && wd) && n < 20) begin
         @(negedge clk);
         if (awvalid && awready) awd = 1;
         if (wvalid && wready) wd = 1;
         @(posedge clk); #1;
         if (awd) awvalid = 1'b0;
         if (wd) wvalid = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      l = 0;
      while (!bvalid && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
      r = bresp;
      check("wr_bvalid_seen", 32'(bvalid), 32'd1);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] dat, output logic [1:0] r);
      bit hs;
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
      do begin
         @(negedge clk);
         hs = arready;
         @(posedge clk); #1;
         n++;
      end while (!hs && n < 20);
      arvalid = 1'b0;
      check("rd_rvalid_next_cycle", 32'(rvalid), 32'd1);
      dat = rdata; r = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic write_and_check(input string tag, input logic [4:0] a, input logic [31:0] dat,
                                  input logic [3:0] s);
      logic [1:0] r_dut, r_m;
      int l;
      axi_write(a, dat, s, r_dut, l);
      m_write(a, dat, s, r_m);
      check({tag, "_bresp"}, 32'(r_dut), 32'(r_m));
      check({tag, "_blat"}, 32'(l), 32'd0);
   endtask

   task automatic read_and_check(input string tag, input logic [4:0] a);
      logic [31:0] d_dut, d_m;
      logic [1:0]  r_dut, r_m;
      m_read(a, d_m, r_m);
      axi_read(a, d_dut, r_dut);
      check({tag, "_rdata"}, d_dut, d_m);
      check({tag, "_rresp"}, 32'(r_dut), 32'(r_m));
   endtask

   // AW, W and AR all presented together; the read sees the pre-write contents.
   task automatic concurrent(input string tag, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [4:0] ra);
      logic [31:0] d_m;
      logic [1:0]  r_m, wr_m;
      m_read(ra, d_m, r_m);
      awaddr = wa; wdata = wd; wstrb = 4'hF; araddr = ra;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      check({tag, "_all_ready"}, {29'd0, awready, wready, arready}, 32'd7);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      m_write(wa, wd, 4'hF, wr_m);
      check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "_old_rdata"}, rdata, d_m);
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
      check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
      check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
      @(posedge clk); #1;

      // RW registers read back exactly
      write_and_check("wr_ctrl", 5'h00, 32'h0101FFFF, 4'hF);
      write_and_check("wr_pix0", 5'h04, 32'hABCD0001, 4'hF);
      write_and_check("wr_pix1", 5'h08, 32'hDEAD0011, 4'hF);
      write_and_check("wr_scr", 5'h0C, 32'hBEEF0011, 4'hF);
      read_and_check("rd_ctrl", 5'h00);
      read_and_check("rd_pix0", 5'h04);
      read_and_check("rd_pix1", 5'h08);
      read_and_check("rd_scr", 5'h0C);
      write_and_check("wr_ctrl_clr", 5'h00, 32'h00000001, 4'hF);
      read_and_check("rd_count0", 5'h14);

      // Conversion of the reference pixels
      write_and_check("wr_pix0b", 5'h04, 32'h00FF8040, 4'hF);
      write_and_check("wr_pix1b", 5'h08, 32'h00123456, 4'hF);
      axi_read(5'h10, d, resp);
`ifdef RGB565_ROUND_EN
      check("result_const", d, 32'h11ABFC08);
`else
      check("result_const", d, 32'h11AAFC08);
`endif
      read_and_check("rd_result", 5'h10);
      axi_read(5'h14, d, resp);
      check("count_two", d, 32'd2);

      // Saturating / full-scale pixels
      write_and_check("wr_sat0", 5'h04, 32'h00FFFFFF, 4'hF);
      axi_read(5'h10, d, resp);
      check("sat_ffffff", {16'd0, d[15:0]}, 32'h0000FFFF);
      write_and_check("wr_sat1", 5'h04, 32'h00FCFEFC, 4'hF);
      axi_read(5'h10, d, resp);
      check("sat_fcfefc", {16'd0, d[15:0]}, 32'h0000FFFF);

      // W arrives three cycles before AW; B held while BREADY low
      bready = 1'b0;
      wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      check("early_w_wready_low", 32'(wready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("early_w_no_bvalid", 32'(bvalid), 32'd0);
      awaddr = 5'h0C; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      m_write(5'h0C, 32'h5A5A5A5A, 4'hF, exp_r);
      check("early_w_bvalid", 32'(bvalid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bvalid_held", 32'(bvalid), 32'd1);
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("bvalid_dropped", 32'(bvalid), 32'd0);
      read_and_check("rd_scr_early", 5'h0C);

      // Clear, RO write, unmapped accesses
      write_and_check("wr_ctrl_one", 5'h00, 32'h00000001, 4'hF);
      read_and_check("rd_count_clr", 5'h14);
      axi_read(5'h10, old_d, resp);
      write_and_check("wr_ro_result", 5'h10, 32'h12345678, 4'hF);
      axi_read(5'h10, d, resp);
      check("result_unchanged", d, old_d);
      read_and_check("rd_unmapped_1c", 5'h1C);
      write_and_check("wr_unmapped_18", 5'h18, 32'hFFFFFFFF, 4'hF);

      // Read sampled on the write-commit edge returns old data
      concurrent("cc_pix0", 5'h04, 32'h00406080, 5'h04);
      concurrent("cc_result", 5'h08, 32'h00F0F0F0, 5'h10);
      read_and_check("rd_result_new", 5'h10);

      // Reset while BVALID pending
      bready = 1'b0;
      awaddr = 5'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("pend_bvalid", 32'(bvalid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      check("rst_mid_bvalid", 32'(bvalid), 32'd0);
      for (int i = 0; i < 6; i++) read_and_check("rd_after_rst", 5'(i * 4));
      write_and_check("wr_after_rst", 5'h0C, 32'h600DF00D, 4'hF);
      read_and_check("rd_after_rst_scr", 5'h0C);

      // Randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         logic [4:0]  a;
         logic [31:0] rd;
         logic [3:0]  s;
         a  = 5'($urandom_range(0, 7) * 4);
         rd = $urandom;
         s  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) write_and_check("rnd_wr", a, rd, s);
         else                           read_and_check("rnd_rd", a);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
